// File: rtl/pwm_timing_ctrl.sv
// pwm_timing_ctrl
// Timing and configuration front end for the photonic-switch PWM generator.
// Derives the frame load strobe (clkZ) and the two count strobes (clkA, clkB)
// from the core clock. A/B compare values, frame length and prescalers are
// double-buffered: writes land in a shadow set that is copied into the active
// set in one step at the frame boundary. While the block is stopped, the copy
// happens on the next edge.
module pwm_timing_ctrl #(
   parameter int CNT_W     = 7,
   parameter int PRE_W     = 8,
   parameter int FRAME_W   = 16,
   parameter int FRAME_DEF = 100,
   parameter int FRAME_MIN = 4
) (
   input  logic               clkCore,
   input  logic               reset_b,
   input  logic               en,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [1:0]         wr_sel,
   input  logic [15:0]        wr_data,
   output logic [CNT_W-1:0]   A_val,
   output logic [CNT_W-1:0]   B_val,
   output logic               clkZ,
   output logic               clkA,
   output logic               clkB,
   output logic               pending,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam logic [FRAME_W-1:0] LEN_DEF = FRAME_W'(FRAME_DEF);
   localparam logic [FRAME_W-1:0] LEN_MIN = FRAME_W'(FRAME_MIN);

   // shadow (write-side) configuration
   logic [CNT_W-1:0]   sh_a;
   logic [CNT_W-1:0]   sh_b;
   logic [FRAME_W-1:0] sh_len;
   logic [PRE_W-1:0]   sh_pre_a;
   logic [PRE_W-1:0]   sh_pre_b;

   // active configuration and counters
   logic [FRAME_W-1:0] frame_len;
   logic [PRE_W-1:0]   pre_a;
   logic [PRE_W-1:0]   pre_b;
   logic [PRE_W-1:0]   pc_a;
   logic [PRE_W-1:0]   pc_b;

   // next-state helpers
   logic [FRAME_W-1:0] last_cnt;
   logic [FRAME_W-1:0] cnt_nxt;
   logic [FRAME_W-1:0] len_wr;
   logic [PRE_W-1:0]   pre_a_nxt;
   logic [PRE_W-1:0]   pre_b_nxt;
   logic [PRE_W-1:0]   pc_a_nxt;
   logic [PRE_W-1:0]   pc_b_nxt;
   logic               at_wrap;
   logic               restart;
   logic               wr_fire;
   logic               commit;

   // strobe registers before run-enable gating
   logic               clkz_q;
   logic               clka_q;
   logic               clkb_q;

   // Frame position decode, write handshake, commit condition and next counter values.
   // The last cycle of a running frame is reserved for the commit, so writes stall there;
   // a stopped block restarts its frame every edge, which also makes commits transparent.
   always_comb begin
      last_cnt  = frame_len - FRAME_W'(1);
      at_wrap   = en && (frame_cnt >= last_cnt);
      restart   = !en || at_wrap;
      wr_ready  = !at_wrap;
      wr_fire   = wr_valid && !at_wrap;
      commit    = pending && restart;
      cnt_nxt   = restart ? '0 : frame_cnt + FRAME_W'(1);
      pre_a_nxt = commit ? sh_pre_a : pre_a;
      pre_b_nxt = commit ? sh_pre_b : pre_b;
      pc_a_nxt  = '0;
      pc_b_nxt  = '0;
      if (!restart) begin
         pc_a_nxt = (pc_a >= pre_a) ? '0 : pc_a + PRE_W'(1);
         pc_b_nxt = (pc_b >= pre_b) ? '0 : pc_b + PRE_W'(1);
      end
      len_wr = (wr_data[FRAME_W-1:0] < LEN_MIN) ? LEN_MIN : wr_data[FRAME_W-1:0];
   end

   // Capture accepted writes into the shadow set; a later write in the same frame overwrites.
   always_ff @(posedge clkCore or negedge reset_b) begin
      if (!reset_b) begin
         sh_a     <= '0;
         sh_b     <= '0;
         sh_len   <= LEN_DEF;
         sh_pre_a <= '0;
         sh_pre_b <= '0;
      end else if (wr_fire) begin
         case (wr_sel)
            2'd0:    sh_a   <= wr_data[CNT_W-1:0];
            2'd1:    sh_b   <= wr_data[CNT_W-1:0];
            2'd2:    sh_len <= len_wr;
            default: begin
               sh_pre_b <= wr_data[8 +: PRE_W];
               sh_pre_a <= wr_data[0 +: PRE_W];
            end
         endcase
      end
   end

   // Copy the whole shadow set into the active set at once when a commit fires, and track
   // whether the shadow holds anything not yet committed.
   always_ff @(posedge clkCore or negedge reset_b) begin
      if (!reset_b) begin
         A_val     <= '0;
         B_val     <= '0;
         frame_len <= LEN_DEF;
         pre_a     <= '0;
         pre_b     <= '0;
         pending   <= 1'b0;
      end else begin
         if (commit) begin
            A_val     <= sh_a;
            B_val     <= sh_b;
            frame_len <= sh_len;
            pre_a     <= sh_pre_a;
            pre_b     <= sh_pre_b;
         end
         if (wr_fire) begin
            pending <= 1'b1;
         end else if (commit) begin
            pending <= 1'b0;
         end
      end
   end

   // Frame counter, frame-aligned prescaler counters and the strobes they produce.
   // Strobes are computed from next-state values so each one is high in the same cycle
   // as the counter position it marks.
   always_ff @(posedge clkCore or negedge reset_b) begin
      if (!reset_b) begin
         frame_cnt <= '0;
         pc_a      <= '0;
         pc_b      <= '0;
         clkz_q    <= 1'b0;
         clka_q    <= 1'b0;
         clkb_q    <= 1'b0;
      end else begin
         frame_cnt <= cnt_nxt;
         pc_a      <= pc_a_nxt;
         pc_b      <= pc_b_nxt;
         clkz_q    <= en && (cnt_nxt == FRAME_W'(1));
         clka_q    <= en && (pc_a_nxt == pre_a_nxt);
         clkb_q    <= en && (pc_b_nxt == pre_b_nxt);
      end
   end

   // Strobes are cut off as soon as the run enable drops.
   assign clkZ = clkz_q & en;
   assign clkA = clka_q & en;
   assign clkB = clkb_q & en;

endmodule

// File: tb/tb_pwm_timing_ctrl.sv
// tb_pwm_timing_ctrl
// Directed bench for pwm_timing_ctrl. The stimulus process drives one cycle at a
// time and queues the hand-computed expected outputs for that cycle. A separate
// monitor on the falling edge pops each queued entry and compares it against the DUT.
module tb_pwm_timing_ctrl;

   localparam int CNT_W   = 7;
   localparam int FRAME_W = 16;

   localparam int S_AVAL  = 0;
   localparam int S_BVAL  = 1;
   localparam int S_CLKZ  = 2;
   localparam int S_CLKA  = 3;
   localparam int S_CLKB  = 4;
   localparam int S_PEND  = 5;
   localparam int S_FCNT  = 6;
   localparam int S_READY = 7;

   logic               clkCore = 1'b0;
   logic               reset_b;
   logic               en;
   logic               wr_valid;
   logic               wr_ready;
   logic [1:0]         wr_sel;
   logic [15:0]        wr_data;
   logic [CNT_W-1:0]   A_val;
   logic [CNT_W-1:0]   B_val;
   logic               clkZ;
   logic               clkA;
   logic               clkB;
   logic               pending;
   logic [FRAME_W-1:0] frame_cnt;

   typedef struct {
      int    cyc;
      int    sig;
      int    val;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   cyc        = 0;
   int   compared   = 0;
   int   mismatched = 0;

   pwm_timing_ctrl dut (
      .clkCore   (clkCore),
      .reset_b   (reset_b),
      .en        (en),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .A_val     (A_val),
      .B_val     (B_val),
      .clkZ      (clkZ),
      .clkA      (clkA),
      .clkB      (clkB),
      .pending   (pending),
      .frame_cnt (frame_cnt)
   );

   // core clock, 10 time units per cycle
   always #5 clkCore = ~clkCore;

   // count rising edges so queued expectations can be tied to a cycle
   always @(posedge clkCore) cyc <= cyc + 1;

   function automatic int sample(input int sig);
      case (sig)
         S_AVAL:  return int'(A_val);
         S_BVAL:  return int'(B_val);
         S_CLKZ:  return int'(clkZ);
         S_CLKA:  return int'(clkA);
         S_CLKB:  return int'(clkB);
         S_PEND:  return int'(pending);
         S_FCNT:  return int'(frame_cnt);
         S_READY: return int'(wr_ready);
         default: return -1;
      endcase
   endfunction

   function automatic string sig_name(input int sig);
      case (sig)
         S_AVAL:  return "A_val";
         S_BVAL:  return "B_val";
         S_CLKZ:  return "clkZ";
         S_CLKA:  return "clkA";
         S_CLKB:  return "clkB";
         S_PEND:  return "pending";
         S_FCNT:  return "frame_cnt";
         S_READY: return "wr_ready";
         default: return "unknown";
      endcase
   endfunction

   task automatic apply_stimulus(input logic e, input logic v, input logic [1:0] s,
                                 input logic [15:0] d);
      en       = e;
      wr_valid = v;
      wr_sel   = s;
      wr_data  = d;
   endtask

   task automatic want(input int sig, input int val, input string tag);
      exp_t it;
      it.cyc = cyc;
      it.sig = sig;
      it.val = val;
      it.tag = tag;
      sb.push_back(it);
   endtask

   task automatic step();
      @(posedge clkCore);
      #1;
   endtask

   task automatic want_reset_values(input string tag);
      want(S_AVAL, 0, tag);
      want(S_BVAL, 0, tag);
      want(S_CLKZ, 0, tag);
      want(S_CLKA, 0, tag);
      want(S_CLKB, 0, tag);
      want(S_PEND, 0, tag);
      want(S_FCNT, 0, tag);
      want(S_READY, 1, tag);
   endtask

   task automatic check_output(input exp_t it);
      int act;
      act = sample(it.sig);
      compared++;
      if (it.cyc != cyc) begin
         mismatched++;
         $display("[TB] FAIL %s: %s checked late (queued for cycle %0d, now %0d)",
                  it.tag, sig_name(it.sig), it.cyc, cyc);
      end else if (act != it.val) begin
         mismatched++;
         $display("[TB] FAIL %s: %s actual=%0d required=%0d (cycle %0d)",
                  it.tag, sig_name(it.sig), act, it.val, cyc);
      end
   endtask

   // monitor: compare every expectation queued for the current cycle, away from the active edge
   always @(negedge clkCore) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         check_output(sb.pop_front());
      end
   end

   // hard stop in case the stimulus ever stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: run did not complete, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // directed stimulus with hand-computed expectations
   initial begin
      int fc;
      int cur;
      int last;
      int exp_b;

      reset_b = 1'b0;
      apply_stimulus(1'b1, 1'b0, 2'd0, 16'd0);
      step();
      step();
      want_reset_values("reset_initial");
      step();
      reset_b = 1'b1;

      // default frame of 100 cycles, no writes, prescalers at 0
      for (int k = 0; k <= 205; k++) begin
         want(S_FCNT, k % 100, "dflt_fcnt");
         want(S_CLKZ, (k % 100 == 1) ? 1 : 0, "dflt_clkz");
         want(S_AVAL, 0, "dflt_aval");
         if (k >= 1) begin
            want(S_CLKA, 1, "dflt_clka");
            want(S_CLKB, 1, "dflt_clkb");
         end
         step();
      end

      // stop mid-frame: strobes vanish, counter returns to 0 on the next edge
      apply_stimulus(1'b0, 1'b0, 2'd0, 16'd0);
      want(S_FCNT, 6, "stop_fcnt_hold");
      want(S_CLKA, 0, "stop_clka_gated");
      want(S_READY, 1, "stop_ready");
      step();
      want(S_FCNT, 0, "stop_fcnt_zero");
      want(S_CLKB, 0, "stop_clkb");

      // frame length 10 while stopped commits on the following edge
      apply_stimulus(1'b0, 1'b1, 2'd2, 16'd10);
      want(S_READY, 1, "len10_ready");
      step();
      apply_stimulus(1'b0, 1'b0, 2'd0, 16'd0);
      want(S_PEND, 1, "len10_pending");
      step();
      want(S_PEND, 0, "len10_committed");

      // run with frame 10, write A_val=37 at frame_cnt=4
      for (int k = 0; k < 20; k++) begin
         fc = k % 10;
         if (k == 4) apply_stimulus(1'b1, 1'b1, 2'd0, 16'd37);
         else        apply_stimulus(1'b1, 1'b0, 2'd0, 16'd0);
         want(S_FCNT, fc, "a37_fcnt");
         want(S_AVAL, (k >= 10) ? 37 : 0, "a37_aval");
         want(S_PEND, (k >= 5 && k <= 9) ? 1 : 0, "a37_pending");
         want(S_CLKZ, (fc == 1) ? 1 : 0, "a37_clkz");
         want(S_READY, (fc != 9) ? 1 : 0, "a37_ready");
         step();
      end

      // continuous B_val writes; data only advances when the write is accepted
      cur   = 1;
      last  = 0;
      exp_b = 0;
      for (int k = 20; k < 50; k++) begin
         fc = k % 10;
         apply_stimulus(1'b1, 1'b1, 2'd1, 16'(cur));
         want(S_FCNT, fc, "stream_fcnt");
         want(S_READY, (fc != 9) ? 1 : 0, "stream_ready");
         want(S_BVAL, exp_b, "stream_bval");
         want(S_PEND, (fc != 0) ? 1 : 0, "stream_pending");
         want(S_AVAL, 37, "stream_aval");
         if (fc != 9) begin
            last = cur;
            cur++;
         end else begin
            exp_b = last;
         end
         step();
      end

      // frame 20 with prescalers preB=2, preA=4, committed at the next wrap
      for (int k = 50; k < 100; k++) begin
         if (k == 50)      apply_stimulus(1'b1, 1'b1, 2'd2, 16'd20);
         else if (k == 51) apply_stimulus(1'b1, 1'b1, 2'd3, 16'h0204);
         else              apply_stimulus(1'b1, 1'b0, 2'd0, 16'd0);
         fc = (k < 60) ? (k % 10) : ((k - 60) % 20);
         want(S_FCNT, fc, "pre_fcnt");
         want(S_BVAL, 27, "pre_bval");
         want(S_CLKZ, (fc == 1) ? 1 : 0, "pre_clkz");
         want(S_PEND, (k >= 51 && k <= 59) ? 1 : 0, "pre_pending");
         if (k < 60) begin
            want(S_CLKA, 1, "pre_old_clka");
            want(S_CLKB, 1, "pre_old_clkb");
         end else begin
            want(S_CLKA, (fc % 5 == 4) ? 1 : 0, "pre_clka");
            want(S_CLKB, (fc % 3 == 2) ? 1 : 0, "pre_clkb");
         end
         step();
      end

      // frame length 2 clamps to 4; preA=4 never completes inside a 4-cycle frame
      for (int k = 100; k < 136; k++) begin
         if (k == 100) apply_stimulus(1'b1, 1'b1, 2'd2, 16'd2);
         else          apply_stimulus(1'b1, 1'b0, 2'd0, 16'd0);
         fc = (k < 120) ? ((k - 100) % 20) : ((k - 120) % 4);
         want(S_FCNT, fc, "min_fcnt");
         want(S_CLKZ, (fc == 1) ? 1 : 0, "min_clkz");
         want(S_PEND, (k >= 101 && k <= 119) ? 1 : 0, "min_pending");
         if (k < 120) begin
            want(S_READY, (fc != 19) ? 1 : 0, "min_ready20");
            want(S_CLKA, (fc % 5 == 4) ? 1 : 0, "min_clka20");
         end else begin
            want(S_READY, (fc != 3) ? 1 : 0, "min_ready4");
            want(S_CLKA, 0, "min_clka4");
            want(S_CLKB, (fc == 2) ? 1 : 0, "min_clkb4");
         end
         step();
      end

      // pending B_val=99, then en drops mid-frame
      apply_stimulus(1'b1, 1'b1, 2'd1, 16'd99);
      want(S_FCNT, 0, "drop_fcnt0");
      step();
      apply_stimulus(1'b1, 1'b0, 2'd0, 16'd0);
      want(S_PEND, 1, "drop_pending");
      want(S_BVAL, 27, "drop_bval_old");
      want(S_CLKZ, 1, "drop_clkz");
      step();
      apply_stimulus(1'b0, 1'b0, 2'd0, 16'd0);
      want(S_FCNT, 2, "drop_fcnt2");
      want(S_CLKZ, 0, "drop_clkz_off");
      want(S_CLKB, 0, "drop_clkb_off");
      want(S_BVAL, 27, "drop_bval_kept");
      want(S_PEND, 1, "drop_pending_kept");
      step();
      want(S_FCNT, 0, "drop_fcnt_zero");
      want(S_BVAL, 99, "drop_bval_commit");
      want(S_PEND, 0, "drop_pending_clear");
      want(S_AVAL, 37, "drop_aval_kept");
      want(S_CLKZ, 0, "drop_clkz_idle");
      want(S_CLKA, 0, "drop_clka_idle");
      want(S_CLKB, 0, "drop_clkb_idle");
      step();

      // restart, queue A_val=55, then reset mid-frame
      apply_stimulus(1'b1, 1'b0, 2'd0, 16'd0);
      want(S_FCNT, 0, "rerun_fcnt0");
      step();
      apply_stimulus(1'b1, 1'b1, 2'd0, 16'd55);
      want(S_FCNT, 1, "rerun_fcnt1");
      want(S_CLKZ, 1, "rerun_clkz");
      step();
      apply_stimulus(1'b1, 1'b0, 2'd0, 16'd0);
      want(S_PEND, 1, "rerun_pending");
      want(S_AVAL, 37, "rerun_aval");
      step();
      reset_b = 1'b0;
      want_reset_values("reset_async");
      step();
      want_reset_values("reset_held");
      step();
      reset_b = 1'b1;

      // after reset the default frame is back and the queued A_val is gone
      for (int j = 0; j < 6; j++) begin
         want(S_FCNT, j, "post_fcnt");
         want(S_CLKZ, (j == 1) ? 1 : 0, "post_clkz");
         want(S_AVAL, 0, "post_aval");
         want(S_PEND, 0, "post_pending");
         step();
      end

      step();
      step();
      while (sb.size() > 0) begin
         exp_t it;
         it = sb.pop_front();
         compared++;
         mismatched++;
         $display("[TB] FAIL %s: %s never checked, actual=unchecked required=%0d",
                  it.tag, sig_name(it.sig), it.val);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
